// File: rtl/modex.sv
// modex: bet and credit controller for the slot-machine datapath.
// Edge-detects the front-panel buttons and tracks the bet and the stored credit.
module modex #(
    parameter int STO_INIT = 10,
    parameter int BET_INIT = 1,
    parameter int WIN_MULT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       betinp,
    input  logic       pause,
    input  logic       betinm,
    input  logic       won,
    output logic [3:0] bet,
    output logic [3:0] sto
);

    localparam logic S_BET  = 1'b0;
    localparam logic S_SPIN = 1'b1;

    logic       state;
    logic       state_n;
    logic       paid;
    logic       paid_n;
    logic [3:0] bet_n;
    logic [3:0] sto_n;

    logic betinp_q;
    logic pause_q;
    logic betinm_q;
    logic won_q;

    logic rise_p;
    logic rise_m;
    logic rise_w;
    logic rise_s;
    logic fall_s;

    logic [7:0] prod;
    logic [7:0] sum;
    logic [3:0] sto_w;

    assign rise_p = betinp & ~betinp_q;
    assign rise_m = betinm & ~betinm_q;
    assign rise_w = won & ~won_q;
    assign rise_s = pause & ~pause_q;
    assign fall_s = ~pause & pause_q;

    // Payout is formed at 8 bits so the saturation sees the true sum.
    assign prod = 8'(WIN_MULT) * {4'd0, bet};
    assign sum  = {4'd0, sto} + prod;

    always_comb begin
        state_n = state;
        paid_n  = paid;
        bet_n   = bet;
        sto_n   = sto;
        sto_w   = sto;
        if (state == S_BET) begin
            if (fall_s) begin
                if (bet <= sto && sto != 4'd0) begin
                    sto_n   = sto - bet;
                    state_n = S_SPIN;
                    paid_n  = 1'b0;
                end
            end else if (rise_p && !rise_m) begin
                if (bet < 4'd15 && bet < sto) begin
                    bet_n = bet + 4'd1;
                end
            end else if (rise_m && !rise_p) begin
                if (bet > 4'd1) begin
                    bet_n = bet - 4'd1;
                end
            end
        end else begin
            if (rise_w && !paid) begin
                sto_w  = (sum > 8'd15) ? 4'd15 : sum[3:0];
                paid_n = 1'b1;
            end
            sto_n = sto_w;
            // The clamp uses the credit after any same-edge payout.
            if (rise_s) begin
                state_n = S_BET;
                if (sto_w != 4'd0 && bet > sto_w) begin
                    bet_n = sto_w;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        betinp_q <= betinp;
        pause_q  <= pause;
        betinm_q <= betinm;
        won_q    <= won;
        if (rst) begin
            state <= S_BET;
            paid  <= 1'b0;
            bet   <= 4'(BET_INIT);
            sto   <= 4'(STO_INIT);
        end else begin
            state <= state_n;
            paid  <= paid_n;
            bet   <= bet_n;
            sto   <= sto_n;
        end
    end

endmodule

// File: tb/tb_modex.sv
// tb_modex: scoreboard bench for the modex bet/credit controller.
// Each step queues the expected {bet,sto} and compares after the edge.
module tb_modex;

    logic       clk;
    logic       rst;
    logic       betinp;
    logic       pause;
    logic       betinm;
    logic       won;
    logic [3:0] bet;
    logic [3:0] sto;

    int checks;
    int errors;

    logic [7:0] sb[$];

    modex dut (
        .clk   (clk),
        .rst   (rst),
        .betinp(betinp),
        .pause (pause),
        .betinm(betinm),
        .won   (won),
        .bet   (bet),
        .sto   (sto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given input levels and expected outputs after it.
    task automatic step(input string tag, input logic r,
                        input logic bp, input logic ps,
                        input logic bm, input logic wn,
                        input int eb, input int es);
        logic [7:0] e;
        rst    = r;
        betinp = bp;
        pause  = ps;
        betinm = bm;
        won    = wn;
        sb.push_back({4'(eb), 4'(es)});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".bet"}, {4'd0, bet}, {4'd0, e[7:4]});
            chk({tag, ".sto"}, {4'd0, sto}, {4'd0, e[3:0]});
        end
    endtask

    task automatic up(input string tag, input int eb, input int es);
        step(tag, 0, 1, 1, 0, 0, eb, es);
        step(tag, 0, 0, 1, 0, 0, eb, es);
    endtask

    task automatic dn(input string tag, input int eb, input int es);
        step(tag, 0, 0, 1, 1, 0, eb, es);
        step(tag, 0, 0, 1, 0, 0, eb, es);
    endtask

    task automatic do_rst();
        step("rst", 1, 0, 1, 0, 0, 1, 10);
        step("rst_rel", 0, 0, 1, 0, 0, 1, 10);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with buttons held high; release must create no edges.
        step("rst_hold0", 1, 1, 1, 1, 1, 1, 10);
        step("rst_hold1", 1, 1, 1, 1, 1, 1, 10);
        step("rst_held", 0, 1, 1, 1, 1, 1, 10);
        step("rst_drop", 0, 0, 1, 0, 0, 1, 10);

        up("inc1", 2, 10);
        up("inc2", 3, 10);
        dn("dec1", 2, 10);
        dn("dec2", 1, 10);
        dn("dec_min0", 1, 10);
        dn("dec_min1", 1, 10);
        up("inc3", 2, 10);
        step("both", 0, 1, 1, 1, 0, 2, 10);
        step("both_rel", 0, 0, 1, 0, 0, 2, 10);

        // Spin without win.
        up("inc4", 3, 10);
        step("spin_a", 0, 0, 0, 0, 0, 3, 7);
        step("frz_up", 0, 1, 0, 0, 0, 3, 7);
        step("frz_rel", 0, 0, 0, 0, 0, 3, 7);
        step("frz_dn", 0, 0, 0, 1, 0, 3, 7);
        step("frz_rel2", 0, 0, 0, 0, 0, 3, 7);
        step("ret_a", 0, 0, 1, 0, 0, 3, 7);

        // Spin with win; second win in same spin is not paid.
        do_rst();
        up("inc5", 2, 10);
        step("spin_b", 0, 0, 0, 0, 0, 2, 8);
        step("win1", 0, 0, 0, 0, 1, 2, 12);
        step("win1_rel", 0, 0, 0, 0, 0, 2, 12);
        step("win2", 0, 0, 0, 0, 1, 2, 12);
        step("win2_rel", 0, 0, 0, 0, 0, 2, 12);
        step("ret_b", 0, 0, 1, 0, 0, 2, 12);

        // Saturating payout.
        up("inc6", 3, 12);
        up("inc7", 4, 12);
        step("spin_c", 0, 0, 0, 0, 0, 4, 8);
        step("win_sat", 0, 0, 0, 0, 1, 4, 15);
        step("win_rel", 0, 0, 0, 0, 0, 4, 15);
        step("ret_c", 0, 0, 1, 0, 0, 4, 15);
        step("won_bet", 0, 0, 1, 0, 1, 4, 15);
        step("won_bet_rel", 0, 0, 1, 0, 0, 4, 15);

        // Bet ceiling at 15.
        for (int i = 5; i <= 15; i++) up("inc_top", i, 15);
        up("inc_max", 15, 15);
        step("spin_all", 0, 0, 0, 0, 0, 15, 0);
        step("ret_zero", 0, 0, 1, 0, 0, 15, 0);
        step("blk_zero", 0, 0, 0, 0, 0, 15, 0);
        step("blk_rel", 0, 0, 1, 0, 0, 15, 0);

        // Losing spins down to a clamp, then blocked at zero credit.
        do_rst();
        up("c1", 2, 10);
        up("c2", 3, 10);
        up("c3", 4, 10);
        step("spin_d", 0, 0, 0, 0, 0, 4, 6);
        step("ret_d", 0, 0, 1, 0, 0, 4, 6);
        step("spin_e", 0, 0, 0, 0, 0, 4, 2);
        step("clamp", 0, 0, 1, 0, 0, 2, 2);
        step("spin_f", 0, 0, 0, 0, 0, 2, 0);
        step("ret_f", 0, 0, 1, 0, 0, 2, 0);
        step("blocked", 0, 0, 0, 0, 0, 2, 0);
        step("blk_rel2", 0, 0, 1, 0, 0, 2, 0);
        up("inc_nocr", 2, 0);
        dn("dec_nocr", 1, 0);
        step("blocked1", 0, 0, 0, 0, 0, 1, 0);
        step("blk_rel3", 0, 0, 1, 0, 0, 1, 0);

        // Fall of pause with a button edge: button ignored.
        do_rst();
        step("fall_btn", 0, 1, 0, 0, 0, 1, 9);
        step("fall_btn_r", 0, 0, 1, 0, 0, 1, 9);

        // Win and return on the same edge: payout then clamp.
        up("w1", 2, 9);
        up("w2", 3, 9);
        step("spin_g", 0, 0, 0, 0, 0, 3, 6);
        step("win_ret", 0, 0, 1, 0, 1, 3, 12);
        step("win_ret_r", 0, 0, 1, 0, 0, 3, 12);

        // Reset mid-spin returns to BET.
        step("spin_h", 0, 0, 0, 0, 0, 3, 9);
        step("rst_spin", 1, 0, 0, 0, 0, 1, 10);
        step("rst_spin_r", 0, 0, 0, 0, 0, 1, 10);
        step("post_rst", 0, 1, 0, 0, 0, 2, 10);
        step("post_rst_r", 0, 0, 0, 0, 0, 2, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
